// File: rtl/mm_fact_unit.sv
// Memory-mapped factorial unit: software writes N and GO over the data bus,
// then polls STATUS and reads RESULT once the iterative multiply completes.
module mm_fact_unit #(
    parameter int unsigned MAX_N = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MULT,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  n;
    logic [3:0]  cnt;
    logic        go;
    logic        done;
    logic        err;
    logic [31:0] result;
    logic [31:0] prod;

    logic wr_n;
    logic wr_go;

    assign wr_n  = we && (a == 2'd0);
    assign wr_go = we && (a == 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            n      <= 4'd0;
            go     <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= 32'd0;
            cnt    <= 4'd0;
            prod   <= 32'd0;
        end else begin
            // Clearing GO is always allowed; setting it only starts work from IDLE.
            if (wr_go && !wd[0])
                go <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_n)
                        n <= wd[3:0];
                    if (wr_go) begin
                        go <= wd[0];
                        if (wd[0]) begin
                            done  <= 1'b0;
                            err   <= 1'b0;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    cnt  <= n;
                    prod <= 32'd1;
                    if (32'(n) > MAX_N) begin
                        err    <= 1'b1;
                        done   <= 1'b1;
                        result <= 32'd0;
                        state  <= IDLE;
                    end else begin
                        state <= MULT;
                    end
                end
                MULT: begin
                    if (cnt <= 4'd1) begin
                        state <= DONE;
                    end else begin
                        prod <= prod * {28'd0, cnt};
                        cnt  <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    result <= prod;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd = 32'd0;
        case (a)
            2'd0:    rd = {28'd0, n};
            2'd1:    rd = {31'd0, go};
            2'd2:    rd = {30'd0, err, done};
            default: rd = result;
        endcase
    end

endmodule

// File: tb/tb_mm_fact_unit.sv
// Directed bench for mm_fact_unit: register map, factorial results,
// completion latency, error path, ignored writes and mid-run reset.
module tb_mm_fact_unit;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    int n_checks;
    int n_fail;

    mm_fact_unit #(.MAX_N(12)) dut (
        .clk(clk),
        .rst(rst),
        .we (we),
        .a  (a),
        .wd (wd),
        .rd (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     tag, obs, obs, exp, exp);
        end
    endtask

    task automatic wr(input logic [1:0] aa, input logic [31:0] d);
        we = 1'b1;
        a  = aa;
        wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [1:0] aa,
                         input logic [31:0] exp);
        a = aa;
        #1;
        chk(tag, rd, exp);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        we  = 1'b0;
        a   = 2'd0;
        wd  = 32'd0;
        tick(2);
        rst = 1'b0;

        rdchk("rst_n",      2'd0, 32'd0);
        rdchk("rst_go",     2'd1, 32'd0);
        rdchk("rst_status", 2'd2, 32'd0);
        rdchk("rst_result", 2'd3, 32'd0);

        // N=5: status low for 6 edges, done on the 7th
        wr(2'd0, 32'd5);
        rdchk("n5_nreg", 2'd0, 32'd5);
        wr(2'd1, 32'd1);
        rdchk("n5_go", 2'd1, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            rdchk($sformatf("n5_busy_e%0d", k), 2'd2, 32'd0);
        end
        tick(1);
        rdchk("n5_status", 2'd2, 32'd1);
        rdchk("n5_result", 2'd3, 32'd120);

        // read-only registers ignore writes
        wr(2'd3, 32'hdead_beef);
        wr(2'd2, 32'd2);
        rdchk("ro_result", 2'd3, 32'd120);
        rdchk("ro_status", 2'd2, 32'd1);

        // N=0 and N=1 both finish on the 3rd edge with 1
        wr(2'd0, 32'd0);
        wr(2'd1, 32'd1);
        tick(2);
        rdchk("n0_busy", 2'd2, 32'd0);
        tick(1);
        rdchk("n0_status", 2'd2, 32'd1);
        rdchk("n0_result", 2'd3, 32'd1);

        wr(2'd0, 32'd1);
        wr(2'd1, 32'd1);
        tick(2);
        rdchk("n1_busy", 2'd2, 32'd0);
        tick(1);
        rdchk("n1_status", 2'd2, 32'd1);
        rdchk("n1_result", 2'd3, 32'd1);

        // N=12, the largest legal value
        wr(2'd0, 32'd12);
        wr(2'd1, 32'd1);
        tick(13);
        rdchk("n12_busy", 2'd2, 32'd0);
        tick(1);
        rdchk("n12_status", 2'd2, 32'd1);
        rdchk("n12_result", 2'd3, 32'd479001600);

        // N=13 is an error, flagged on the first edge after GO
        wr(2'd0, 32'd13);
        wr(2'd1, 32'd0);
        rdchk("go_clear", 2'd1, 32'd0);
        wr(2'd1, 32'd1);
        rdchk("n13_go_edge", 2'd2, 32'd0);
        tick(1);
        rdchk("n13_status", 2'd2, 32'd3);
        rdchk("n13_result", 2'd3, 32'd0);

        // writes during MULT are ignored
        wr(2'd0, 32'd6);
        wr(2'd1, 32'd1);
        tick(1);
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd1);
        rdchk("busy_nreg", 2'd0, 32'd6);
        tick(5);
        rdchk("n6_status", 2'd2, 32'd1);
        rdchk("n6_result", 2'd3, 32'd720);
        rdchk("n6_nreg", 2'd0, 32'd6);
        tick(3);
        rdchk("n6_no_restart", 2'd2, 32'd1);

        // reset mid-MULT aborts and clears everything
        wr(2'd0, 32'd10);
        wr(2'd1, 32'd1);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rdchk("mrst_n",      2'd0, 32'd0);
        rdchk("mrst_go",     2'd1, 32'd0);
        rdchk("mrst_status", 2'd2, 32'd0);
        rdchk("mrst_result", 2'd3, 32'd0);
        tick(12);
        rdchk("mrst_idle", 2'd2, 32'd0);
        wr(2'd0, 32'd4);
        wr(2'd1, 32'd1);
        tick(6);
        rdchk("n4_status", 2'd2, 32'd1);
        rdchk("n4_result", 2'd3, 32'd24);

        // result persists across a restart until the next DONE
        wr(2'd0, 32'd5);
        wr(2'd1, 32'd1);
        tick(7);
        rdchk("r5_result", 2'd3, 32'd120);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd1);
        rdchk("r3_done_clr", 2'd2, 32'd0);
        rdchk("r3_hold0", 2'd3, 32'd120);
        tick(4);
        rdchk("r3_hold4", 2'd3, 32'd120);
        rdchk("r3_busy4", 2'd2, 32'd0);
        tick(1);
        rdchk("r3_status", 2'd2, 32'd1);
        rdchk("r3_result", 2'd3, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
